// File: rtl/qdec_cabac_reg_bank.sv
// Register bank with a start/done handshake per channel, W1C interrupt status,
// and double-buffered config registers.
module qdec_cabac_reg_bank #(
    parameter int                          DATA_W   = 32,
    parameter int                          ADDR_W   = 8,
    parameter int                          NUM_CFG  = 8,
    parameter int                          NUM_CH   = 2,
    parameter logic [NUM_CFG*DATA_W-1:0]   CFG_MASK = '1,
    parameter int                          LOAD_CH  = 0,
    parameter logic [DATA_W-1:0]           BAD_DATA = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic [NUM_CH-1:0]         start_o,
    input  logic [NUM_CH-1:0]         done_i,
    output logic [NUM_CH-1:0]         busy_o,
    output logic [NUM_CFG*DATA_W-1:0] cfg_o,
    output logic                      irq_o
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_ISTAT  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_IEN    = ADDR_W'(8'h0C);

    // Done bits live at [NUM_CH-1:0], start-while-busy errors at [16+NUM_CH-1:16].
    function automatic logic [DATA_W-1:0] irq_mask_f();
        logic [DATA_W-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m[c]      = 1'b1;
            m[16 + c] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [DATA_W-1:0] IRQ_MASK = irq_mask_f();

    logic [NUM_CFG-1:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_CFG-1:0][DATA_W-1:0] cfg_q, cfg_d;
    logic [DATA_W-1:0]              stat_q, stat_d;
    logic [DATA_W-1:0]              en_q, en_d;
    logic [NUM_CH-1:0]              busy_q, busy_d;
    logic [NUM_CH-1:0]              start_q, start_d;
    logic [DATA_W-1:0]              rd_data_q, rd_data_d;
    logic                           rd_valid_q, rd_valid_d;
    logic                           irq_q, irq_d;

    logic              ctrl_wr, stat_wr, en_wr;
    logic [NUM_CH-1:0] accept, err, done_set;
    logic [DATA_W-1:0] hw_set, rd_mux;

    always_comb begin
        ctrl_wr = wr_en && (wr_addr == A_CTRL);
        stat_wr = wr_en && (wr_addr == A_ISTAT);
        en_wr   = wr_en && (wr_addr == A_IEN);

        // A start is judged against the busy flag as it stands this cycle,
        // so a coincident done does not make the channel eligible yet.
        accept   = ctrl_wr ? (wr_data[NUM_CH-1:0] & ~busy_q) : '0;
        err      = ctrl_wr ? (wr_data[NUM_CH-1:0] &  busy_q) : '0;
        done_set = done_i & busy_q;

        busy_d  = accept | (busy_q & ~done_set);
        start_d = accept;

        hw_set               = '0;
        hw_set[NUM_CH-1:0]   = done_set;
        hw_set[16 +: NUM_CH] = err;
        stat_d = ((stat_q & ~(stat_wr ? wr_data : '0)) | hw_set) & IRQ_MASK;
        en_d   = en_wr ? (wr_data & IRQ_MASK) : en_q;
        irq_d  = |(stat_q & en_q);

        shadow_d = shadow_q;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(16 + 4 * i)))
                shadow_d[i] = wr_data & CFG_MASK[i*DATA_W +: DATA_W];
        end
        // Commit uses the pre-write shadow; a same-cycle CFG write waits for the next load.
        cfg_d = accept[LOAD_CH] ? shadow_q : cfg_q;

        rd_mux = BAD_DATA;
        if (rd_addr == A_CTRL)   rd_mux = '0;
        if (rd_addr == A_STATUS) rd_mux = DATA_W'(busy_q);
        if (rd_addr == A_ISTAT)  rd_mux = stat_q;
        if (rd_addr == A_IEN)    rd_mux = en_q;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (rd_addr == ADDR_W'(16 + 4 * i)) rd_mux = shadow_q[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            cfg_q      <= '0;
            stat_q     <= '0;
            en_q       <= '0;
            busy_q     <= '0;
            start_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            stat_q     <= stat_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign start_o  = start_q;
    assign busy_o   = busy_q;
    assign cfg_o    = cfg_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_qdec_cabac_reg_bank.sv
// Randomised bench for qdec_cabac_reg_bank against a register-level reference model.
module tb_qdec_cabac_reg_bank;

    localparam logic [255:0] MASKS = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                      32'h00FF00FF, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'hFFFFFFFF};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0]   wr_addr = '0, rd_addr = '0;
    logic [31:0]  wr_data = '0;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic [1:0]   start_o, busy_o;
    logic [1:0]   done_i = '0;
    logic [255:0] cfg_o;
    logic         irq_o;

    qdec_cabac_reg_bank #(.DATA_W(32), .ADDR_W(8), .NUM_CFG(8), .NUM_CH(2),
                          .CFG_MASK(MASKS), .LOAD_CH(0), .BAD_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .start_o(start_o), .done_i(done_i), .busy_o(busy_o),
        .cfg_o(cfg_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_shadow [8];
    logic [31:0] m_cfg    [8];
    logic [31:0] m_stat, m_en;
    bit   [1:0]  m_busy;
    bit          m_irq;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cfg_mask(input int i);
        logic [255:0] m;
        m = MASKS;
        return m[i*32 +: 32];
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return 32'h0;
        if (ai == 4) return {30'h0, m_busy};
        if (ai == 8) return m_stat;
        if (ai == 12) return m_en;
        if (ai >= 16 && ai < 48 && (ai % 4) == 0) return m_shadow[(ai - 16) / 4];
        return 32'hDEADBEEF;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = '0;
            m_cfg[i]    = '0;
        end
        m_stat = '0; m_en = '0; m_busy = '0; m_irq = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_start"}, start_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_cfg"}, cfg_o, 0);
        chk({tag, "_irq"}, irq_o, 0);
    endtask

    // One clock cycle: drive, advance the model, check every output.
    task automatic step(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                        input bit re, input logic [7:0] ra, input logic [1:0] dn);
        logic [31:0] e_rd, n_stat, set_bits;
        bit   [1:0]  n_busy, e_start;
        bit          e_irq;
        logic [255:0] e_cfg;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; done_i = dn;

        e_rd     = model_read(ra);
        e_irq    = |(m_stat & m_en);
        e_start  = '0;
        set_bits = '0;
        n_busy   = m_busy;
        for (int c = 0; c < 2; c++) begin
            if (we && wa == 8'h00 && wd[c]) begin
                if (!m_busy[c]) e_start[c] = 1'b1;
                else            set_bits[16 + c] = 1'b1;
            end
            if (dn[c] && m_busy[c]) begin
                set_bits[c] = 1'b1;
                n_busy[c]   = 1'b0;
            end
            if (e_start[c]) n_busy[c] = 1'b1;
        end
        n_stat = m_stat;
        if (we && wa == 8'h08) n_stat = n_stat & ~wd;
        n_stat = (n_stat | set_bits) & 32'h0003_0003;
        if (e_start[0])
            for (int i = 0; i < 8; i++) m_cfg[i] = m_shadow[i];
        if (we && wa == 8'h0C) m_en = wd & 32'h0003_0003;
        if (we && int'(wa) >= 16 && int'(wa) < 48 && wa[1:0] == 2'b00)
            m_shadow[(int'(wa) - 16) / 4] = wd & cfg_mask((int'(wa) - 16) / 4);
        m_stat = n_stat;
        m_busy = n_busy;
        m_irq  = e_irq;

        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; done_i = '0;
        for (int i = 0; i < 8; i++) e_cfg[i*32 +: 32] = m_cfg[i];
        chk("start", start_o, e_start);
        chk("busy", busy_o, m_busy);
        chk("cfg", cfg_o, e_cfg);
        chk("irq", irq_o, m_irq);
        chk("rd_valid", rd_valid, re);
        if (re) chk("rd_data", rd_data, e_rd);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 8'h00, 32'h0, 1'b1, a, 2'b00);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 2'b00);
    endtask

    logic [7:0] addrs [15] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                               8'h20, 8'h2C, 8'h30, 8'h80, 8'h11, 8'hFC, 8'h00};

    initial begin
        model_clear();
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // masked CFG write, read-back one cycle later, active copy untouched
        wr(8'h14, 32'hFFFFFFFF);
        rd(8'h14);
        chk("cfg1_read", rd_data, 32'h0FFFFFFF);
        chk("cfg1_active", cfg_o[63:32], 32'h0);
        wr(8'h10, 32'h12345678);
        wr(8'h1C, 32'hA5A5A5A5);

        // start ch0 commits shadow; second start while busy flags error
        wr(8'h00, 32'h1);
        chk("start_pulse", start_o, 2'b01);
        chk("cfg0_commit", cfg_o[31:0], 32'h12345678);
        chk("cfg3_commit", cfg_o[127:96], 32'h00A500A5);
        idle();
        chk("start_one_cycle", start_o, 2'b00);
        wr(8'h00, 32'h1);
        chk("busy_no_pulse", start_o, 2'b00);
        rd(8'h08);
        chk("err_stat", rd_data, 32'h00010000);

        // done -> irq, then W1C clears irq the following cycle
        wr(8'h0C, 32'h1);
        step(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 2'b01);
        chk("done_busy", busy_o, 2'b00);
        idle();
        chk("irq_set", irq_o, 1'b1);
        wr(8'h08, 32'h1);
        idle();
        chk("irq_clr", irq_o, 1'b0);
        wr(8'h08, 32'h10000);

        // set beats clear on the same bit
        wr(8'h00, 32'h2);
        step(1'b1, 8'h08, 32'h2, 1'b0, 8'h00, 2'b10);
        rd(8'h08);
        chk("set_over_w1c", rd_data[1], 1'b1);

        // coincident done and start while busy: rejected, reported, then idle
        wr(8'h00, 32'h1);
        step(1'b1, 8'h00, 32'h1, 1'b0, 8'h00, 2'b01);
        chk("start_done_same", start_o, 2'b00);
        rd(8'h08);

        // same-cycle read/write returns pre-write value
        step(1'b1, 8'h18, 32'hCAFEF00D, 1'b1, 8'h18, 2'b00);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] d;
            logic [1:0]  dn;
            d  = $urandom;
            dn = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step($urandom_range(0, 1) == 1, addrs[$urandom_range(0, 14)], d,
                 $urandom_range(0, 1) == 1, addrs[$urandom_range(0, 14)], dn);
        end

        // reset mid-operation with both channels busy and a read in flight
        #2 rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h00, 32'h3, 1'b1, 8'h80, 2'b00);
        chk("both_busy", busy_o, 2'b11);
        chk("bad_read", rd_data, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_held");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        rd(8'h04);
        chk("status_after_rst", rd_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
